// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states and lane masks.
package mem_pkg;

    localparam logic [1:0] BHW_BYTE = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD_DONE   = 2'd1,
        ST_STORE_MERGE = 2'd2
    } mem_state_e;

    // Bits of the 32-bit word touched by an access of size bhw at byte offset off.
    function automatic logic [31:0] lane_mask(input logic [1:0] bhw, input logic [1:0] off);
        logic [31:0] m;
        if (bhw[1])
            m = 32'hFFFF_FFFF;
        else if (bhw == BHW_HALF)
            m = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        else
            m = 32'h0000_00FF << {off, 3'b000};
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_access_ram.sv
// Single-port synchronous data RAM: registered read, full-word write, no reset on contents.
module data_ram #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we)
                mem[i_addr] <= i_wdata;
            else
                rdata_q <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data access: byte/half/word loads and stores on data_ram, sub-word stores by read-modify-write.
module mem_stage_access
    import mem_pkg::*;
#(
    parameter int INST_SZ = 32,
    parameter int ADDR_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_bhw,
    input  logic               i_unsigned,
    input  logic [INST_SZ-1:0] i_alu_result,
    input  logic [INST_SZ-1:0] i_write_data,
    output logic [INST_SZ-1:0] o_read_data,
    output logic               o_rd_valid,
    output logic               o_stall,
    output logic               o_access_err
);

    mem_state_e          state_q, state_d;
    logic [1:0]          off_q, off_d;
    logic [1:0]          bhw_q, bhw_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;

    logic                ram_en, ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [INST_SZ-1:0]  ram_wdata, ram_rdata;

    logic [ADDR_W-1:0]   req_widx;
    logic [1:0]          req_off;
    logic                misaligned, bad_req;
    logic                unused_addr_bits;

    assign req_widx = i_alu_result[ADDR_W+1:2];
    assign req_off  = i_alu_result[1:0];
    assign unused_addr_bits = ^i_alu_result[INST_SZ-1:ADDR_W+2];

    assign misaligned = ((i_bhw == BHW_HALF) && req_off[0]) || (i_bhw[1] && (req_off != 2'b00));
    assign bad_req    = (i_mem_read && i_mem_write) || misaligned;

    // Load lane extraction and extension, using the size/offset captured at issue.
    logic [INST_SZ-1:0] lane_shift, load_fmt;
    assign lane_shift = ram_rdata >> {off_q, 3'b000};

    always_comb begin
        load_fmt = ram_rdata;
        if (bhw_q == BHW_BYTE)
            load_fmt = {{(INST_SZ-8){~uns_q & lane_shift[7]}}, lane_shift[7:0]};
        else if (bhw_q == BHW_HALF)
            load_fmt = {{(INST_SZ-16){~uns_q & lane_shift[15]}}, lane_shift[15:0]};
    end

    // Store data replicated to every lane, then merged into the old word under the lane mask.
    logic [INST_SZ-1:0] store_rep, store_mask, store_merged;
    assign store_rep    = (bhw_q == BHW_HALF) ? {2{i_write_data[15:0]}} : {4{i_write_data[7:0]}};
    assign store_mask   = lane_mask(bhw_q, off_q);
    assign store_merged = (ram_rdata & ~store_mask) | (store_rep & store_mask);

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        bhw_d        = bhw_q;
        uns_d        = uns_q;
        widx_d       = widx_q;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = req_widx;
        ram_wdata    = i_write_data;
        o_stall      = 1'b0;
        o_rd_valid   = 1'b0;
        o_read_data  = '0;
        o_access_err = 1'b0;

        // Reset suppresses every output and any RAM write, including a pending merge.
        if (!i_reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_mem_read || i_mem_write) begin
                        if (bad_req) begin
                            o_access_err = 1'b1;
                        end else begin
                            off_d  = req_off;
                            bhw_d  = i_bhw;
                            uns_d  = i_unsigned;
                            widx_d = req_widx;
                            ram_en = 1'b1;
                            if (i_mem_write && i_bhw[1]) begin
                                ram_we = 1'b1;
                            end else begin
                                o_stall = 1'b1;
                                state_d = i_mem_read ? ST_LOAD_DONE : ST_STORE_MERGE;
                            end
                        end
                    end
                end
                ST_LOAD_DONE: begin
                    o_rd_valid  = 1'b1;
                    o_read_data = load_fmt;
                    state_d     = ST_IDLE;
                end
                ST_STORE_MERGE: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = widx_q;
                    ram_wdata = store_merged;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            bhw_q   <= '0;
            uns_q   <= 1'b0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            bhw_q   <= bhw_d;
            uns_q   <= uns_d;
            widx_q  <= widx_d;
        end
    end

    data_ram #(.DW(INST_SZ), .AW(ADDR_W)) u_data_ram (
        .i_clk   (i_clk),
        .i_en    (ram_en),
        .i_we    (ram_we),
        .i_addr  (ram_addr),
        .i_wdata (ram_wdata),
        .o_rdata (ram_rdata)
    );

endmodule
